// File: rtl/pipelined_multiplier_hs_if.sv
// Handshake bundle for the pipelined multiplier: operand side, result side and flush.
// The slave modport is the multiplier; the master modport is the producer/consumer around it.
interface pipelined_multiplier_hs_if #(
    parameter int DATA_WIDTH = 8
);
    logic                      flush_i;
    logic                      valid_i;
    logic                      ready_o;
    logic                      signed_i;
    logic [DATA_WIDTH-1:0]     operand_A_i;
    logic [DATA_WIDTH-1:0]     operand_B_i;
    logic                      valid_o;
    logic                      ready_i;
    logic [2*DATA_WIDTH-1:0]   product_o;

    modport slave (
        input  flush_i,
        input  valid_i,
        input  signed_i,
        input  operand_A_i,
        input  operand_B_i,
        input  ready_i,
        output ready_o,
        output valid_o,
        output product_o
    );

    modport master (
        output flush_i,
        output valid_i,
        output signed_i,
        output operand_A_i,
        output operand_B_i,
        output ready_i,
        input  ready_o,
        input  valid_o,
        input  product_o
    );
endinterface

// File: rtl/pipelined_multiplier_hs.sv
// Pipelined shift-add array multiplier with valid/ready handshake on both sides.
// Signed operands travel as magnitudes plus a sign flag; the last stage negates when needed.
module pipelined_multiplier_hs #(
    parameter int DATA_WIDTH        = 8,
    parameter int PRODUCT_PER_STAGE = 4
) (
    input logic                      clk_i,
    input logic                      rst_i,
    pipelined_multiplier_hs_if.slave bus
);
    localparam int W          = DATA_WIDTH;
    localparam int STAGES     = DATA_WIDTH / PRODUCT_PER_STAGE;
    localparam int REG_STAGES = (STAGES > 1) ? STAGES - 1 : 1;
    localparam logic [W-1:0]   ONE_W  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [2*W-1:0] ONE_2W = {{(2*W-1){1'b0}}, 1'b1};

    logic           advance_s;
    logic [W-1:0]   a_mag_s;
    logic [W-1:0]   b_mag_s;
    logic           sign_s;

    logic           vld_r   [REG_STAGES];
    logic           sgn_r   [REG_STAGES];
    logic           carry_r [REG_STAGES];
    logic [W-1:0]   sum_r   [REG_STAGES];
    logic [W-1:0]   low_r   [REG_STAGES];
    logic [W-1:0]   mb_r    [REG_STAGES];
    logic [W-1:0]   mc_r    [REG_STAGES];

    logic           valid_o_r;
    logic [2*W-1:0] product_r;

    assign advance_s     = bus.ready_i | ~valid_o_r;
    assign bus.ready_o   = advance_s;
    assign bus.valid_o   = valid_o_r;
    assign bus.product_o = product_r;

    // Operand conditioning: magnitudes fit in W bits, even for the most-negative value.
    always_comb begin
        if (bus.signed_i) begin
            a_mag_s = bus.operand_A_i[W-1] ? ((~bus.operand_A_i) + ONE_W) : bus.operand_A_i;
            b_mag_s = bus.operand_B_i[W-1] ? ((~bus.operand_B_i) + ONE_W) : bus.operand_B_i;
            sign_s  = bus.operand_A_i[W-1] ^ bus.operand_B_i[W-1];
        end else begin
            a_mag_s = bus.operand_A_i;
            b_mag_s = bus.operand_B_i;
            sign_s  = 1'b0;
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        logic           in_vld_s;
        logic           in_sgn_s;
        logic           in_carry_s;
        logic [W-1:0]   in_sum_s;
        logic [W-1:0]   in_low_s;
        logic [W-1:0]   in_mb_s;
        logic [W-1:0]   in_mc_s;
        logic           carry_s;
        logic [W-1:0]   sum_s;
        logic [W-1:0]   low_s;
        logic [W-1:0]   mb_s;
        logic [W-1:0]   pp_s;

        if (g == 0) begin : g_src_in
            assign in_vld_s   = bus.valid_i & ~bus.flush_i;
            assign in_sgn_s   = sign_s;
            assign in_carry_s = 1'b0;
            assign in_sum_s   = {W{1'b0}};
            assign in_low_s   = {W{1'b0}};
            assign in_mb_s    = b_mag_s;
            assign in_mc_s    = a_mag_s;
        end else begin : g_src_reg
            assign in_vld_s   = vld_r[g-1];
            assign in_sgn_s   = sgn_r[g-1];
            assign in_carry_s = carry_r[g-1];
            assign in_sum_s   = sum_r[g-1];
            assign in_low_s   = low_r[g-1];
            assign in_mb_s    = mb_r[g-1];
            assign in_mc_s    = mc_r[g-1];
        end

        // Each row adds an AND row to the shifted running sum; sum bit 0 retires into the low half.
        always_comb begin
            carry_s = in_carry_s;
            sum_s   = in_sum_s;
            low_s   = in_low_s;
            mb_s    = in_mb_s;
            pp_s    = {W{1'b0}};
            for (int r = 0; r < PRODUCT_PER_STAGE; r++) begin
                pp_s             = {carry_s, sum_s[W-1:1]};
                {carry_s, sum_s} = {1'b0, pp_s} + {1'b0, in_mc_s & {W{mb_s[0]}}};
                low_s            = {sum_s[0], low_s[W-1:1]};
                mb_s             = {1'b0, mb_s[W-1:1]};
            end
        end

        if (g < STAGES - 1) begin : g_reg
            // Stage valid bit: cleared by reset or flush, otherwise moves with the pipeline.
            always_ff @(posedge clk_i) begin
                if (rst_i || bus.flush_i) begin
                    vld_r[g] <= 1'b0;
                end else if (advance_s) begin
                    vld_r[g] <= in_vld_s;
                end else begin
                    vld_r[g] <= vld_r[g];
                end
            end

            // Stage data carries no reset; it only matters when the valid bit is set.
            always_ff @(posedge clk_i) begin
                if (advance_s) begin
                    sgn_r[g]   <= in_sgn_s;
                    carry_r[g] <= carry_s;
                    sum_r[g]   <= sum_s;
                    low_r[g]   <= low_s;
                    mb_r[g]    <= mb_s;
                    mc_r[g]    <= in_mc_s;
                end else begin
                    sgn_r[g]   <= sgn_r[g];
                    carry_r[g] <= carry_r[g];
                    sum_r[g]   <= sum_r[g];
                    low_r[g]   <= low_r[g];
                    mb_r[g]    <= mb_r[g];
                    mc_r[g]    <= mc_r[g];
                end
            end
        end else begin : g_out
            logic [2*W-1:0] mag_s;
            logic [2*W-1:0] prod_s;

            // Assemble the full magnitude and apply the travelling sign; -0 stays 0.
            always_comb begin
                mag_s = {carry_s, sum_s[W-1:1], low_s};
                if (in_sgn_s) begin
                    prod_s = (~mag_s) + ONE_2W;
                end else begin
                    prod_s = mag_s;
                end
            end

            // Output register: product only changes when a real result lands.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    valid_o_r <= 1'b0;
                    product_r <= {(2*W){1'b0}};
                end else if (bus.flush_i) begin
                    valid_o_r <= 1'b0;
                    product_r <= product_r;
                end else if (advance_s) begin
                    valid_o_r <= in_vld_s;
                    product_r <= in_vld_s ? prod_s : product_r;
                end else begin
                    valid_o_r <= valid_o_r;
                    product_r <= product_r;
                end
            end
        end
    end
endmodule

// File: doc/pipelined_multiplier_hs.md
PIPELINED_MULTIPLIER_HS -- requirements
Module: pipelined_multiplier_hs

Interface
REQ-001 Parameter DATA_WIDTH, default 8, operand width in bits; SHALL be a power of 2 and at least 4.
REQ-002 Parameter PRODUCT_PER_STAGE, default 4, partial-product rows per pipeline stage; SHALL be a power of 2 dividing DATA_WIDTH.
REQ-003 Derived STAGES = DATA_WIDTH / PRODUCT_PER_STAGE SHALL set the pipeline depth.
REQ-004 Port clk_i, input, 1, single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_i, input, 1, reset, synchronous and active-high.
REQ-006 Port flush_i, input, 1, synchronous discard of all in-flight operations.
REQ-007 Port valid_i, input, 1, operand pair is present.
REQ-008 Port ready_o, output, 1, block accepts the operand pair this cycle.
REQ-009 Port signed_i, input, 1, 1 = two's-complement operands, 0 = unsigned.
REQ-010 Port operand_A_i, input, DATA_WIDTH, multiplicand.
REQ-011 Port operand_B_i, input, DATA_WIDTH, multiplier.
REQ-012 Port valid_o, output, 1, product_o holds a result.
REQ-013 Port ready_i, input, 1, consumer takes the result this cycle.
REQ-014 Port product_o, output, 2*DATA_WIDTH, full-width product.

Function
REQ-015 The datapath SHALL be an array multiplier split into STAGES register stages, each stage resolving PRODUCT_PER_STAGE rows of AND products with ripple rows, and each stage register holding:
- the running partial product
- the row carry
- the already-resolved low result bits
- the remaining multiplier bits
- the multiplicand
- the sign flag
- a valid bit
REQ-016 Global advance = ready_i OR NOT valid_o; ready_o SHALL equal advance; when advance is 0, every stage register SHALL hold its value.
REQ-017 An operation SHALL be accepted when valid_i AND ready_o; when advance is 1 and valid_i is 0, a bubble (valid bit 0) SHALL enter stage 1.
REQ-018 Latency SHALL be exactly STAGES cycles from acceptance to valid_o with no stall, plus one cycle per stalled cycle. Throughput SHALL be one result per cycle.
REQ-019 Signed mode: at acceptance, operands SHALL be replaced by their magnitudes, and sign = MSB(A) XOR MSB(B) SHALL travel with the operation.
REQ-020 The most-negative operand SHALL map to magnitude 2^(DATA_WIDTH-1) without overflow.
REQ-021 The final stage SHALL two's-complement negate the 2*DATA_WIDTH magnitude when sign = 1; unsigned mode SHALL force sign = 0.
REQ-022 signed_i SHALL be sampled per operation; consecutive operations may alternate mode.
REQ-023 product_o SHALL be exact modulo 2^(2*DATA_WIDTH) for every operand pair in both modes. No overflow is possible.
REQ-024 Zero operands SHALL give product 0 in both modes, including a zero magnitude with sign = 1.
REQ-025 flush_i = 1 SHALL clear all stage valid bits and valid_o at the next edge, regardless of ready_i. Any operation presented in the same cycle SHALL be discarded. ready_o SHALL remain per REQ-016.
REQ-026 Simultaneous output handshake and new acceptance SHALL both take effect with no lost or duplicated results.
REQ-027 product_o SHALL be held stable while valid_o = 1 and ready_i = 0.

Reset
REQ-028 While rst_i = 1 at a rising edge, all stage valid bits and valid_o SHALL become 0, and product_o SHALL become 0.
REQ-029 Reset mid-operation SHALL discard all in-flight operations; no result from before reset SHALL appear afterwards.
REQ-030 Data registers other than product_o need no reset value; only the valid path SHALL be reset.
REQ-031 ready_o SHALL be 1 in the first cycle after reset is released.

Verification (DATA_WIDTH = 8, PRODUCT_PER_STAGE = 4, STAGES = 2)
REQ-032 Unsigned 255 x 255, ready_i = 1 -> valid_o rises 2 cycles later with product_o = 16'hFE01.
REQ-033 Signed cases -> product_o values:
- -128 x -128 -> 16'h4000
- -1 x 127 -> 16'hFF81
- 0 x -5 -> 16'h0000
REQ-034 Back-to-back stream of 16 random operations with alternating signed_i -> 16 results in order, one per cycle, all matching a reference model.
REQ-035 ready_i held 0 for 3 cycles while the pipeline is full ->
- ready_o = 0 during the stall
- product_o held stable
- no results lost once ready_i returns to 1
REQ-036 flush_i, then rst_i, each asserted with 2 operations in flight -> valid_o = 0 on the next cycle and no stale result ever emitted.
